// File: rtl/link_fifo.sv
`default_nettype none
// ============================================================================
// Module   : link_fifo
// Brief    : First-word-fall-through channel FIFO between adjacent PEs.
//            Optional sticky over/underflow flags when LINK_FIFO_ERR_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module link_fifo #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    input  logic                  rd,
    output logic                  vld,
    output logic [DATA_WIDTH-1:0] dout
`ifdef LINK_FIFO_ERR_EN
    ,
    output logic [1:0]            err
`endif
);

    localparam int unsigned           c_DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   c_CNT_FULL = (ADDR_WIDTH+1)'(c_DEPTH);
    localparam logic [ADDR_WIDTH:0]   c_CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE  = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
    logic [ADDR_WIDTH-1:0] r_wp;
    logic [ADDR_WIDTH-1:0] r_rp;
    logic [ADDR_WIDTH:0]   r_cnt;

    logic w_full;
    logic w_vld;
    logic w_wr_ok;
    logic w_rd_ok;

    // Flags come from the registered count only, so no wr/rd -> flag path.
    assign w_full  = (r_cnt == c_CNT_FULL);
    assign w_vld   = (r_cnt != '0);
    assign w_wr_ok = wr & ~w_full;
    assign w_rd_ok = rd & w_vld;

    assign full = w_full;
    assign vld  = w_vld;
    assign dout = r_mem[r_rp];

    // Storage is never cleared; reset only suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_ok) begin
            r_mem[r_wp] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wp <= r_wp + c_PTR_ONE;
            end
            if (w_rd_ok) begin
                r_rp <= r_rp + c_PTR_ONE;
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_cnt <= r_cnt + c_CNT_ONE;
                2'b01:   r_cnt <= r_cnt - c_CNT_ONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

`ifdef LINK_FIFO_ERR_EN
    logic [1:0] r_err;

    // Sticky diagnostics only; they never gate the datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 2'b00;
        end else begin
            if (wr && w_full) begin
                r_err[0] <= 1'b1;
            end
            if (rd && !w_vld) begin
                r_err[1] <= 1'b1;
            end
        end
    end

    assign err = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_link_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_link_fifo
// Brief    : Scoreboard bench for link_fifo at DEPTH=4 with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_link_fifo;

    localparam int c_DW = 16;
    localparam int c_AW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            wr;
    logic [c_DW-1:0] din;
    logic            full;
    logic            rd;
    logic            vld;
    logic [c_DW-1:0] dout;
    logic [1:0]      err_obs;

    int n_tests = 0;
    int n_fail  = 0;
    bit done    = 1'b0;

    logic [c_DW-1:0] exp_q [$];
    logic [3:0]      flg_q [$];
    string           nm_q  [$];

    always #5 clk = ~clk;

    link_fifo #(
        .DATA_WIDTH (c_DW),
        .ADDR_WIDTH (c_AW)
    ) u_dut (
        .clk  (clk),
        .rst  (rst),
        .wr   (wr),
        .din  (din),
        .full (full),
        .rd   (rd),
        .vld  (vld),
        .dout (dout)
`ifdef LINK_FIFO_ERR_EN
        ,
        .err  (err_obs)
`endif
    );

`ifndef LINK_FIFO_ERR_EN
    assign err_obs = 2'b00;
`endif

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, got, exp);
        end
    endtask

    // One driven cycle: ev/ef/ee are the flags visible before this cycle's edge.
    task automatic cyc(input string nm, input logic w, input logic [c_DW-1:0] d,
                       input logic r, input logic acc, input logic ev,
                       input logic ef, input logic [1:0] ee);
        wr  = w;
        din = w ? d : '0;
        rd  = r;
        if (acc) exp_q.push_back(d);
        nm_q.push_back(nm);
        flg_q.push_back({ev, ef, ee});
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [3:0] f;
        string      nm;
        if (done) begin
            check("leftover_words", 32'(exp_q.size()), 32'd0);
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end else begin
            if (flg_q.size() > 0) begin
                f  = flg_q.pop_front();
                nm = nm_q.pop_front();
                check({nm, "_vld"},  32'(vld),  32'(f[3]));
                check({nm, "_full"}, 32'(full), 32'(f[2]));
`ifdef LINK_FIFO_ERR_EN
                check({nm, "_err"}, 32'(err_obs), 32'(f[1:0]));
`endif
            end
            if (rst === 1'b0 && rd === 1'b1 && vld === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL pop_unexpected: got 0x%0h, required no word", dout);
                end else begin
                    check("pop_data", 32'(dout), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        wr  = 1'b1;
        rd  = 1'b1;
        din = '0;
        @(posedge clk);
        #1;
        // Reset held with wr/rd asserted: nothing may be stored.
        cyc("rst_hold", 1, 16'h0099, 1, 0, 0, 0, 2'b00);
        rst = 1'b0;
        cyc("post_rst", 0, 0, 0, 0, 0, 0, 2'b00);
        cyc("idle",     0, 0, 0, 0, 0, 0, 2'b00);

        // Fill / overflow / drain
        cyc("fill1",    1, 16'h0011, 0, 1, 0, 0, 2'b00);
        cyc("fill2",    1, 16'h0022, 0, 1, 1, 0, 2'b00);
        cyc("fill3",    1, 16'h0033, 0, 1, 1, 0, 2'b00);
        cyc("fill4",    1, 16'h0044, 0, 1, 1, 0, 2'b00);
        cyc("wr_full",  1, 16'h0055, 0, 0, 1, 1, 2'b00);
        cyc("drain1",   0, 0, 1, 0, 1, 1, 2'b01);
        cyc("drain2",   0, 0, 1, 0, 1, 0, 2'b01);
        cyc("drain3",   0, 0, 1, 0, 1, 0, 2'b01);
        cyc("drain4",   0, 0, 1, 0, 1, 0, 2'b01);
        cyc("drained",  0, 0, 0, 0, 0, 0, 2'b01);

        // FWFT latency
        cyc("fwft_wr",  1, 16'h00A5, 0, 1, 0, 0, 2'b01);
        cyc("fwft_rd",  0, 0, 1, 0, 1, 0, 2'b01);
        cyc("fwft_end", 0, 0, 0, 0, 0, 0, 2'b01);

        // Streaming with wrap, occupancy held at 2
        cyc("pre1",     1, 16'h0100, 0, 1, 0, 0, 2'b01);
        cyc("pre2",     1, 16'h0101, 0, 1, 1, 0, 2'b01);
        for (int i = 0; i < 20; i++) begin
            cyc("stream", 1, c_DW'(i), 1, 1, 1, 0, 2'b01);
        end
        cyc("sdrain1",  0, 0, 1, 0, 1, 0, 2'b01);
        cyc("sdrain2",  0, 0, 1, 0, 1, 0, 2'b01);
        cyc("sdone",    0, 0, 0, 0, 0, 0, 2'b01);

        // Full + wr + rd: pop happens, write dropped, 3 words remain
        cyc("bf1",      1, 16'h0200, 0, 1, 0, 0, 2'b01);
        cyc("bf2",      1, 16'h0201, 0, 1, 1, 0, 2'b01);
        cyc("bf3",      1, 16'h0202, 0, 1, 1, 0, 2'b01);
        cyc("bf4",      1, 16'h0203, 0, 1, 1, 0, 2'b01);
        cyc("full_wrrd",1, 16'h0204, 1, 0, 1, 1, 2'b01);
        cyc("cnt3_a",   0, 0, 1, 0, 1, 0, 2'b01);
        cyc("cnt3_b",   0, 0, 1, 0, 1, 0, 2'b01);
        cyc("cnt3_c",   0, 0, 1, 0, 1, 0, 2'b01);
        cyc("cnt3_end", 0, 0, 0, 0, 0, 0, 2'b01);

        // Empty + wr + rd: write accepted, no pop
        cyc("empty_wrrd",1, 16'h0300, 1, 1, 0, 0, 2'b01);
        cyc("cnt1",     0, 0, 0, 0, 1, 0, 2'b11);
        cyc("cnt1_pop", 0, 0, 1, 0, 1, 0, 2'b11);
        cyc("cnt1_end", 0, 0, 0, 0, 0, 0, 2'b11);
        rst = 1'b1;
        cyc("rst_a",    0, 0, 0, 0, 0, 0, 2'b11);
        rst = 1'b0;

        // Reset mid-operation discards stored words
        cyc("mid_w1",   1, 16'h0500, 0, 1, 0, 0, 2'b00);
        cyc("mid_w2",   1, 16'h0501, 0, 1, 1, 0, 2'b00);
        rst = 1'b1;
        exp_q.delete();
        cyc("mid_rst",  1, 16'h0502, 1, 0, 1, 0, 2'b00);
        rst = 1'b0;
        cyc("mid_post", 0, 0, 0, 0, 0, 0, 2'b00);
        cyc("mid_w3",   1, 16'h0503, 0, 1, 0, 0, 2'b00);
        cyc("mid_pop",  0, 0, 1, 0, 1, 0, 2'b00);
        cyc("mid_end",  0, 0, 0, 0, 0, 0, 2'b00);

        // Sticky error flags
        cyc("ef1",      1, 16'h0400, 0, 1, 0, 0, 2'b00);
        cyc("ef2",      1, 16'h0401, 0, 1, 1, 0, 2'b00);
        cyc("ef3",      1, 16'h0402, 0, 1, 1, 0, 2'b00);
        cyc("ef4",      1, 16'h0403, 0, 1, 1, 0, 2'b00);
        cyc("e_ovf",    1, 16'h0404, 0, 0, 1, 1, 2'b00);
        cyc("ed1",      0, 0, 1, 0, 1, 1, 2'b01);
        cyc("ed2",      0, 0, 1, 0, 1, 0, 2'b01);
        cyc("ed3",      0, 0, 1, 0, 1, 0, 2'b01);
        cyc("ed4",      0, 0, 1, 0, 1, 0, 2'b01);
        cyc("e_unf",    0, 0, 1, 0, 0, 0, 2'b01);
        cyc("e_stick1", 0, 0, 0, 0, 0, 0, 2'b11);
        cyc("e_stick2", 0, 0, 0, 0, 0, 0, 2'b11);
        rst = 1'b1;
        cyc("e_rst",    0, 0, 0, 0, 0, 0, 2'b11);
        rst = 1'b0;
        cyc("e_clear",  0, 0, 0, 0, 0, 0, 2'b00);

        wr   = 1'b0;
        rd   = 1'b0;
        done = 1'b1;
    end

endmodule
`default_nettype wire
